// File: rtl/fir_coeff_loader_pkg.sv
// fir_coeff_loader_pkg: loader FSM states and default FIR coefficient format
package fir_coeff_loader_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
    localparam int COEFF_WIDTH = 16;
    localparam int COEFF_FRAC = 14;
endpackage

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: NUM_TAPS x DATA_WIDTH register bank with per-word write and bulk load
module fir_coeff_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_TAPS = 8,
    parameter int AW = $clog2(NUM_TAPS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [AW-1:0]                  waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic                           load,
    input  logic [NUM_TAPS*DATA_WIDTH-1:0] load_data,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= load_data;
        else if (we)
            q[waddr*DATA_WIDTH +: DATA_WIDTH] <= wdata;
    end
endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams coefficients into a shadow bank and commits them atomically to the active bank
module fir_coeff_loader
    import fir_coeff_loader_pkg::*;
#(
    parameter int DATA_WIDTH = COEFF_WIDTH,
    parameter int DATA_WIDTH_F = COEFF_FRAC,
    parameter int NUM_TAPS = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           coeff_valid,
    input  logic signed [DATA_WIDTH-1:0]   coeff_in,
    output logic                           coeff_ready,
    output logic                           busy,
    output logic                           load_done,
    output logic                           h_valid,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] h_out,
    output logic                           fir_hold
);
    localparam int AW = $clog2(NUM_TAPS);
    localparam int IW = AW + 1;
    if (NUM_TAPS < 2 || NUM_TAPS > 64 || DATA_WIDTH_F >= DATA_WIDTH) begin : g_bad_params
        $error("fir_coeff_loader: illegal parameter set");
    end
    state_t state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic wr, last, commit, discard;
    logic [NUM_TAPS*DATA_WIDTH-1:0] shadow;
    assign wr = state == LOAD && coeff_valid && !abort;
    assign last = wr && idx == IW'(NUM_TAPS - 1);
    assign commit = state == COMMIT;
    assign discard = state == LOAD && abort;
    assign coeff_ready = state == LOAD;
    assign busy = state != IDLE;
    assign fir_hold = commit;
    always_comb begin
        state_nxt = state;
        idx_nxt = idx;
        case (state)
            IDLE: begin
                state_nxt = start ? LOAD : IDLE;
                idx_nxt = '0;
            end
            LOAD: begin
                state_nxt = abort ? IDLE : last ? COMMIT : LOAD;
                idx_nxt = wr ? idx + 1'b1 : idx;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            load_done <= 1'b0;
            h_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            idx <= idx_nxt;
            load_done <= commit;
            if (commit)
                h_valid <= 1'b1;
        end
    end
    // an aborted load wipes the shadow so no partial set can leak into a later commit
    fir_coeff_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM_TAPS(NUM_TAPS)) u_shadow (
        .clk(clk),
        .reset(reset),
        .we(wr),
        .waddr(idx[AW-1:0]),
        .wdata(coeff_in),
        .load(discard),
        .load_data('0),
        .q(shadow)
    );
    fir_coeff_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM_TAPS(NUM_TAPS)) u_active (
        .clk(clk),
        .reset(reset),
        .we(1'b0),
        .waddr('0),
        .wdata('0),
        .load(commit),
        .load_data(shadow),
        .q(h_out)
    );
endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: directed vectors checked against a transaction-level model of the loader
module tb_fir_coeff_loader;
    localparam int DW = 16;
    localparam int NT = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic coeff_valid = 1'b0;
    logic signed [DW-1:0] coeff_in = '0;
    logic coeff_ready, busy, load_done, h_valid, fir_hold;
    logic [NT*DW-1:0] h_out;
    int vectors = 0;
    int miscompares = 0;
    fir_coeff_loader dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .coeff_valid(coeff_valid),
        .coeff_in(coeff_in),
        .coeff_ready(coeff_ready),
        .busy(busy),
        .load_done(load_done),
        .h_valid(h_valid),
        .h_out(h_out),
        .fir_hold(fir_hold)
    );
    always #5 clk = ~clk;
    bit armed = 0;
    bit m_loading = 0, m_committing = 0, m_done = 0, m_hv = 0;
    int m_n = 0;
    logic [DW-1:0] m_sh [NT];
    logic [DW-1:0] m_act [NT];
    function automatic logic [NT*DW-1:0] pack(input logic [DW-1:0] a [NT]);
        logic [NT*DW-1:0] r;
        for (int k = 0; k < NT; k++) r[k*DW +: DW] = a[k];
        return r;
    endfunction
    task automatic chk(input string name, input logic [NT*DW-1:0] act, input logic [NT*DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    always @(posedge clk) begin
        if (reset) begin
            armed = 1;
            m_loading = 0;
            m_committing = 0;
            m_done = 0;
            m_hv = 0;
            m_n = 0;
            for (int k = 0; k < NT; k++) begin
                m_sh[k] = '0;
                m_act[k] = '0;
            end
        end else begin
            m_done = m_committing;
            if (m_committing) begin
                m_act = m_sh;
                m_hv = 1;
                m_committing = 0;
            end else if (m_loading) begin
                if (abort) begin
                    m_loading = 0;
                    for (int k = 0; k < NT; k++) m_sh[k] = '0;
                end else if (coeff_valid) begin
                    m_sh[m_n] = coeff_in;
                    m_n++;
                    if (m_n == NT) begin
                        m_loading = 0;
                        m_committing = 1;
                    end
                end
            end else if (start) begin
                m_loading = 1;
                m_n = 0;
            end
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            chk("coeff_ready", {127'd0, coeff_ready}, {127'd0, m_loading});
            chk("busy", {127'd0, busy}, {127'd0, m_loading | m_committing});
            chk("fir_hold", {127'd0, fir_hold}, {127'd0, m_committing});
            chk("load_done", {127'd0, load_done}, {127'd0, m_done});
            chk("h_valid", {127'd0, h_valid}, {127'd0, m_hv});
            chk("h_out", h_out, pack(m_act));
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic run_load(input logic [DW-1:0] w [NT], input int nwords, input bit gap, input int restart_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            coeff_valid = 1'b1;
            coeff_in = w[i];
            start = (i == restart_at);
            tick();
            start = 1'b0;
            if (gap && i < nwords - 1) begin
                coeff_valid = 1'b0;
                coeff_in = 16'h7FFF;
                tick();
                chk("ready_in_gap", {127'd0, coeff_ready}, 128'd1);
            end
        end
        coeff_valid = 1'b0;
    endtask
    logic [DW-1:0] set_a [NT] = '{16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h0100, 16'h0080};
    logic [DW-1:0] set_b [NT] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h0001};
    logic [DW-1:0] set_c [NT] = '{16'h0123, 16'hFEDC, 16'h0A0A, 16'hF5F5, 16'h0042, 16'hFFFF, 16'h1000, 16'hE000};
    logic [DW-1:0] set_n [NT] = '{16'h8000, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060, 16'hC000};
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        int holds;
        tick();
        tick();
        chk("rst_h_out", h_out, 128'd0);
        chk("rst_flags", {123'd0, coeff_ready, busy, load_done, h_valid, fir_hold}, 128'd0);
        reset = 1'b0;
        tick();
        run_load(set_a, NT, 1'b0, -1);
        chk("commit_hold", {126'd0, fir_hold, load_done}, 128'd2);
        tick();
        chk("a_done", {126'd0, load_done, h_valid}, 128'd3);
        chk("a_tap0", {112'd0, h_out[0 +: DW]}, {112'd0, 16'h4000});
        chk("a_tap7", {112'd0, h_out[7*DW +: DW]}, {112'd0, 16'h0080});
        chk("a_all", h_out, pack(set_a));
        tick();
        run_load(set_a, NT, 1'b1, -1);
        chk("gap_hold", {127'd0, fir_hold}, 128'd1);
        tick();
        chk("gap_done", {127'd0, load_done}, 128'd1);
        chk("gap_h_out", h_out, pack(set_a));
        tick();
        run_load(set_b, 3, 1'b0, -1);
        abort = 1'b1;
        coeff_valid = 1'b1;
        coeff_in = 16'h5A5A;
        tick();
        abort = 1'b0;
        coeff_valid = 1'b0;
        chk("abort_idle", {126'd0, busy, coeff_ready}, 128'd0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", {127'd0, load_done}, 128'd0);
            tick();
        end
        chk("abort_h_out", h_out, pack(set_a));
        chk("abort_h_valid", {127'd0, h_valid}, 128'd1);
        coeff_valid = 1'b1;
        coeff_in = 16'h7FFF;
        tick();
        tick();
        coeff_valid = 1'b0;
        chk("idle_valid_ignored", {127'd0, busy}, 128'd0);
        run_load(set_c, NT, 1'b0, 4);
        tick();
        chk("restart_ignored", h_out, pack(set_c));
        tick();
        run_load(set_b, 5, 1'b0, -1);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("mid_rst_h_out", h_out, 128'd0);
        chk("mid_rst_flags", {123'd0, coeff_ready, busy, load_done, h_valid, fir_hold}, 128'd0);
        tick();
        run_load(set_c, NT, 1'b0, -1);
        tick();
        chk("post_rst_load", h_out, pack(set_c));
        tick();
        run_load(set_n, NT, 1'b0, -1);
        holds = 0;
        for (int i = 0; i < 4; i++) begin
            holds += int'(fir_hold);
            tick();
        end
        chk("hold_once", 128'(holds), 128'd1);
        chk("neg_tap0", {112'd0, h_out[0 +: DW]}, {112'd0, 16'h8000});
        chk("neg_tap7", {112'd0, h_out[7*DW +: DW]}, {112'd0, 16'hC000});
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, coefficient word width in bits.
REQ-002 SHALL have parameter DATA_WIDTH_F, default 14, fractional bits of the coefficient word (Q2.14 at defaults).
REQ-003 SHALL have parameter NUM_TAPS, default 8, number of taps in the FIR chain; legal range 2..64.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to begin a coefficient load.
REQ-007 SHALL have port abort  input  1  cancel an in-progress load.
REQ-008 SHALL have port coeff_valid  input  1  coeff_in holds a valid word.
REQ-009 SHALL have port coeff_in  input  DATA_WIDTH (signed)  coefficient word, tap 0 first.
REQ-010 SHALL have port coeff_ready  output  1  loader accepts a word this cycle.
REQ-011 SHALL have port busy  output  1  high in LOAD or COMMIT.
REQ-012 SHALL have port load_done  output  1  one-cycle pulse when new bank becomes active.
REQ-013 SHALL have port h_valid  output  1  active bank holds a committed set.
REQ-014 SHALL have port h_out  output  NUM_TAPS*DATA_WIDTH  active coefficients, tap k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-015 SHALL have port fir_hold  output  1  high during COMMIT so the FIR chain deasserts its enable.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, COMMIT.
REQ-017 IDLE: coeff_ready=0, busy=0; start=1 -> LOAD with write index cleared to 0.
REQ-018 LOAD: coeff_ready=1; word accepted only when coeff_valid and coeff_ready both high in the same cycle.
REQ-019 Accepted word SHALL be written to shadow[index]; index increments by 1 per accepted word.
REQ-020 Acceptance of word at index NUM_TAPS-1 SHALL transition to COMMIT next cycle; coeff_ready=0 in COMMIT.
REQ-021 COMMIT lasts exactly one cycle: fir_hold=1; active bank <= shadow bank; load_done=1, h_valid=1 from the following cycle; then IDLE.
REQ-022 h_out SHALL change only on the clock edge ending COMMIT; all NUM_TAPS words update atomically.
REQ-023 Latency: last accepted word at edge N -> h_out updated and load_done high in cycle N+2.
REQ-024 Gaps in coeff_valid during LOAD SHALL stall the index without timeout.
REQ-025 start while busy SHALL be ignored; coeff_valid in IDLE SHALL be ignored (no write, no state change).
REQ-026 abort in LOAD SHALL return to IDLE next cycle, discard shadow contents, leave h_out and h_valid unchanged; a word presented the same cycle SHALL NOT be written.
REQ-027 abort in COMMIT SHALL be ignored; commit completes.
REQ-028 Words SHALL be stored unmodified (no saturation or rescaling); index counter width SHALL be $clog2(NUM_TAPS)+1.

Reset
REQ-029 reset SHALL take priority over all inputs and force state IDLE, index 0.
REQ-030 Reset values: coeff_ready=0, busy=0, load_done=0, fir_hold=0, h_valid=0, h_out all zero, shadow all zero.
REQ-031 reset asserted mid-LOAD or in COMMIT SHALL discard the load; no load_done pulse is produced.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and default DATA_WIDTH/DATA_WIDTH_F constants used by the FIR chain.
REQ-033 Shadow and active banks SHALL be inside this module; one sub-module, fir_coeff_bank (NUM_TAPS x DATA_WIDTH register array with per-word write and bulk load), is natural and SHALL be used for both banks.

Verification
REQ-034 Reset, then start, 8 back-to-back words 0x4000,0x2000,...,0x0080 -> load_done at cycle N+2, h_out tap0=0x4000, tap7=0x0080, h_valid=1.
REQ-035 Same load with coeff_valid toggling every other cycle -> identical h_out; load_done 2 cycles after 8th handshake; coeff_ready high throughout LOAD.
REQ-036 Load set A, then start, 3 words, abort -> h_out still equals set A, no load_done, FSM in IDLE next cycle.
REQ-037 start asserted during LOAD at word 4 and coeff_valid asserted in IDLE with 0x7FFF -> ignored; final h_out unaffected.
REQ-038 reset asserted after 5 accepted words -> all outputs zero, h_valid=0; fresh full load then succeeds.
REQ-039 Negative coefficients 0x8000 and 0xC000 loaded to taps 0 and 7 -> h_out carries exact bit patterns; fir_hold high for exactly one cycle.
